// File: rtl/score_keeper_pkg.sv
// Shared encodings for the score keeper: match states, latched point events,
// winner codes and the score digit width.
package score_keeper_pkg;
    localparam int SCORE_W = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SERVE = 2'd1,
        S_PLAY  = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        PEND_NONE = 2'd0,
        PEND_P1   = 2'd1,
        PEND_P2   = 2'd2,
        PEND_TIE  = 2'd3
    } pend_t;

    localparam logic [1:0] WINNER_NONE = 2'd0;
    localparam logic [1:0] WINNER_P1   = 2'd1;
    localparam logic [1:0] WINNER_P2   = 2'd2;
endpackage

// File: rtl/score_keeper.sv
// Match flow and per-player score digits; point events are latched during play
// and only applied on frame_start so a digit never changes mid-frame.
module score_keeper
    import score_keeper_pkg::*;
#(
    parameter int WIN_SCORE    = 9,
    parameter int SERVE_FRAMES = 60
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_start,
    input  logic               point_p1,
    input  logic               point_p2,
    input  logic               start_btn,
    output logic [SCORE_W-1:0] score_p1,
    output logic [SCORE_W-1:0] score_p2,
    output logic               serve_en,
    output logic               game_over,
    output logic [1:0]         winner
);
    localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);
    localparam logic [7:0]         SERVE_LAST = 8'(SERVE_FRAMES - 1);

    state_t             state;
    pend_t              pending;
    logic [7:0]         frame_cnt;
    logic               start_q;
    logic               start_rise;
    logic [SCORE_W-1:0] p1_next;
    logic [SCORE_W-1:0] p2_next;

    assign start_rise = start_btn & ~start_q;
    assign p1_next    = score_p1 + 1'b1;
    assign p2_next    = score_p2 + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            pending   <= PEND_NONE;
            frame_cnt <= '0;
            start_q   <= 1'b0;
            score_p1  <= '0;
            score_p2  <= '0;
            serve_en  <= 1'b0;
            game_over <= 1'b0;
            winner    <= WINNER_NONE;
        end else begin
            start_q <= start_btn;
            case (state)
                S_IDLE: begin
                    score_p1  <= '0;
                    score_p2  <= '0;
                    frame_cnt <= '0;
                    if (start_rise) state <= S_SERVE;
                end
                S_SERVE: begin
                    if (frame_start) begin
                        if (frame_cnt == SERVE_LAST) begin
                            state     <= S_PLAY;
                            frame_cnt <= '0;
                            serve_en  <= 1'b1;
                        end else begin
                            frame_cnt <= frame_cnt + 8'd1;
                        end
                    end
                end
                S_PLAY: begin
                    // Only a point latched on an earlier edge is applied here;
                    // a coincident pulse is captured and waits for the next frame.
                    if (frame_start && pending != PEND_NONE) begin
                        pending   <= PEND_NONE;
                        frame_cnt <= '0;
                        serve_en  <= 1'b0;
                        state     <= S_SERVE;
                        case (pending)
                            PEND_P1: begin
                                score_p1 <= p1_next;
                                if (p1_next == WIN_VAL) begin
                                    state     <= S_OVER;
                                    game_over <= 1'b1;
                                    winner    <= WINNER_P1;
                                end
                            end
                            PEND_P2: begin
                                score_p2 <= p2_next;
                                if (p2_next == WIN_VAL) begin
                                    state     <= S_OVER;
                                    game_over <= 1'b1;
                                    winner    <= WINNER_P2;
                                end
                            end
                            default: ;
                        endcase
                    end else if (pending == PEND_NONE) begin
                        if (point_p1 && point_p2) pending <= PEND_TIE;
                        else if (point_p1)        pending <= PEND_P1;
                        else if (point_p2)        pending <= PEND_P2;
                    end
                end
                S_OVER: begin
                    if (start_rise) begin
                        score_p1  <= '0;
                        score_p2  <= '0;
                        winner    <= WINNER_NONE;
                        game_over <= 1'b0;
                        frame_cnt <= '0;
                        state     <= S_SERVE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: directed scenarios plus a randomized run checked
// against a match-level reference model.
module tb_score_keeper;
    localparam int WIN    = 3;
    localparam int FRAMES = 60;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_start = 1'b0, point_p1 = 1'b0, point_p2 = 1'b0, start_btn = 1'b0;
    logic [3:0] score_p1, score_p2;
    logic       serve_en, game_over;
    logic [1:0] winner;

    int checks = 0;
    int failures = 0;

    // reference model: phase 0 idle, 1 serving, 2 playing, 3 finished
    int m_phase, m_s1, m_s2, m_win, m_pend, m_frames;
    bit m_sq;

    score_keeper #(.WIN_SCORE(WIN), .SERVE_FRAMES(FRAMES)) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start),
        .point_p1(point_p1), .point_p2(point_p2), .start_btn(start_btn),
        .score_p1(score_p1), .score_p2(score_p2), .serve_en(serve_en),
        .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    task automatic model_step(input bit fs, input bit p1, input bit p2, input bit sb, input bit rst);
        bit rise;
        if (rst) begin
            m_phase = 0; m_s1 = 0; m_s2 = 0; m_win = 0; m_pend = 0; m_frames = 0; m_sq = 0;
            return;
        end
        rise = sb && !m_sq;
        m_sq = sb;
        case (m_phase)
            0: begin
                m_s1 = 0; m_s2 = 0;
                if (rise) begin m_phase = 1; m_frames = 0; end
            end
            1: if (fs) begin
                m_frames++;
                if (m_frames == FRAMES) m_phase = 2;
            end
            2: begin
                if (fs && m_pend != 0) begin
                    if (m_pend == 1) m_s1++;
                    if (m_pend == 2) m_s2++;
                    m_pend = 0;
                    m_frames = 0;
                    if (m_s1 == WIN) begin m_phase = 3; m_win = 1; end
                    else if (m_s2 == WIN) begin m_phase = 3; m_win = 2; end
                    else m_phase = 1;
                end else if (m_pend == 0) begin
                    m_pend = (p1 && p2) ? 3 : p1 ? 1 : p2 ? 2 : 0;
                end
            end
            default: if (rise) begin
                m_s1 = 0; m_s2 = 0; m_win = 0; m_phase = 1; m_frames = 0;
            end
        endcase
    endtask

    // Drive one clock of inputs, advance the model, then settle past the edge.
    task automatic cyc(input bit fs, input bit p1, input bit p2, input bit sb, input bit rst);
        frame_start = fs; point_p1 = p1; point_p2 = p2; start_btn = sb; reset = rst;
        @(posedge clk);
        model_step(fs, p1, p2, sb, rst);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    task automatic start_pulse();
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
    endtask

    // Exactly FRAMES frame pulses, after which play must be enabled.
    task automatic serve_out();
        for (int i = 0; i < FRAMES; i++) begin
            cyc(1, 0, 0, 0, 0);
            cyc(0, 0, 0, 0, 0);
        end
        checks++;
        if (serve_en !== 1'b1) begin
            failures++;
            $display("FAIL serve_out: serve_en=%0b expected 1 after %0d frames", serve_en, FRAMES);
        end
    endtask

    task automatic test_reset();
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        checks++;
        if ({score_p1, score_p2, serve_en, game_over, winner} !== 12'h0) begin
            failures++;
            $display("FAIL reset: s1=%0d s2=%0d se=%0b go=%0b w=%0d expected all 0",
                     score_p1, score_p2, serve_en, game_over, winner);
        end
    endtask

    task automatic test_start();
        start_pulse();
        for (int i = 0; i < FRAMES - 1; i++) begin
            cyc(1, 0, 0, 0, 0);
            cyc(0, 0, 0, 0, 0);
        end
        checks++;
        if (serve_en !== 1'b0) begin
            failures++;
            $display("FAIL start_early: serve_en=%0b expected 0 after %0d frames", serve_en, FRAMES - 1);
        end
        cyc(1, 0, 0, 0, 0);
        checks++;
        if (serve_en !== 1'b1 || score_p1 !== 4'd0 || score_p2 !== 4'd0) begin
            failures++;
            $display("FAIL start_play: se=%0b s1=%0d s2=%0d expected 1/0/0", serve_en, score_p1, score_p2);
        end
    endtask

    task automatic test_single_point();
        cyc(0, 1, 0, 0, 0);
        idle(100);
        checks++;
        if (score_p1 !== 4'd0 || serve_en !== 1'b1) begin
            failures++;
            $display("FAIL single_hold: s1=%0d se=%0b expected 0/1 before frame", score_p1, serve_en);
        end
        cyc(1, 0, 0, 0, 0);
        checks++;
        if (score_p1 !== 4'd1 || score_p2 !== 4'd0 || serve_en !== 1'b0) begin
            failures++;
            $display("FAIL single_apply: s1=%0d s2=%0d se=%0b expected 1/0/0", score_p1, score_p2, serve_en);
        end
        serve_out();
    endtask

    task automatic test_same_cycle();
        cyc(1, 0, 1, 0, 0);
        idle(3);
        checks++;
        if (score_p2 !== 4'd0 || serve_en !== 1'b1) begin
            failures++;
            $display("FAIL same_cycle_hold: s2=%0d se=%0b expected 0/1", score_p2, serve_en);
        end
        cyc(1, 0, 0, 0, 0);
        checks++;
        if (score_p2 !== 4'd1 || score_p1 !== 4'd1) begin
            failures++;
            $display("FAIL same_cycle_apply: s1=%0d s2=%0d expected 1/1", score_p1, score_p2);
        end
        serve_out();
    endtask

    task automatic test_tie_and_extra();
        cyc(0, 1, 1, 0, 0);
        idle(2);
        cyc(1, 0, 0, 0, 0);
        checks++;
        if (score_p1 !== 4'd1 || score_p2 !== 4'd1 || serve_en !== 1'b0) begin
            failures++;
            $display("FAIL tie: s1=%0d s2=%0d se=%0b expected 1/1/0", score_p1, score_p2, serve_en);
        end
        serve_out();
        cyc(0, 0, 1, 0, 0);
        idle(2);
        cyc(0, 1, 0, 0, 0);
        idle(2);
        cyc(1, 1, 0, 0, 0);
        checks++;
        if (score_p1 !== 4'd1 || score_p2 !== 4'd2) begin
            failures++;
            $display("FAIL extra_pulse: s1=%0d s2=%0d expected 1/2", score_p1, score_p2);
        end
        serve_out();
    endtask

    task automatic test_win();
        cyc(0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        serve_out();
        cyc(0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        checks++;
        if (score_p1 !== 4'd3 || game_over !== 1'b1 || winner !== 2'd1 || serve_en !== 1'b0) begin
            failures++;
            $display("FAIL win: s1=%0d go=%0b w=%0d se=%0b expected 3/1/1/0",
                     score_p1, game_over, winner, serve_en);
        end
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 1, 0, 0);
            cyc(1, 0, 1, 0, 0);
        end
        checks++;
        if (score_p1 !== 4'd3 || score_p2 !== 4'd2 || game_over !== 1'b1 || winner !== 2'd1) begin
            failures++;
            $display("FAIL over_hold: s1=%0d s2=%0d go=%0b w=%0d expected 3/2/1/1",
                     score_p1, score_p2, game_over, winner);
        end
        start_pulse();
        checks++;
        if (score_p1 !== 4'd0 || score_p2 !== 4'd0 || winner !== 2'd0 || game_over !== 1'b0 || serve_en !== 1'b0) begin
            failures++;
            $display("FAIL restart: s1=%0d s2=%0d w=%0d go=%0b se=%0b expected all 0",
                     score_p1, score_p2, winner, game_over, serve_en);
        end
        serve_out();
    endtask

    task automatic test_reset_mid();
        cyc(0, 1, 0, 0, 0); cyc(1, 0, 0, 0, 0); serve_out();
        cyc(0, 1, 0, 0, 0); cyc(1, 0, 0, 0, 0); serve_out();
        cyc(0, 0, 1, 0, 0); cyc(1, 0, 0, 0, 0); serve_out();
        checks++;
        if (score_p1 !== 4'd2 || score_p2 !== 4'd1) begin
            failures++;
            $display("FAIL mid_setup: s1=%0d s2=%0d expected 2/1", score_p1, score_p2);
        end
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        checks++;
        if ({score_p1, score_p2, serve_en, game_over, winner} !== 12'h0) begin
            failures++;
            $display("FAIL mid_reset: s1=%0d s2=%0d se=%0b go=%0b w=%0d expected all 0",
                     score_p1, score_p2, serve_en, game_over, winner);
        end
        start_pulse();
        serve_out();
        cyc(1, 0, 0, 0, 0);
        checks++;
        if (score_p1 !== 4'd0 || serve_en !== 1'b1) begin
            failures++;
            $display("FAIL pending_discard: s1=%0d se=%0b expected 0/1", score_p1, serve_en);
        end
    endtask

    task automatic test_random();
        bit fs, p1, p2, sb, rst;
        cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < 8000; i++) begin
            fs  = ($urandom_range(0, 1) == 0);
            p1  = ($urandom_range(0, 5) == 0);
            p2  = ($urandom_range(0, 5) == 0);
            sb  = ($urandom_range(0, 24) == 0);
            rst = ($urandom_range(0, 2999) == 0);
            cyc(fs, p1, p2, sb, rst);
            checks++;
            if (score_p1 !== 4'(m_s1) || score_p2 !== 4'(m_s2) || serve_en !== (m_phase == 2) ||
                game_over !== (m_phase == 3) || winner !== 2'(m_win)) begin
                failures++;
                $display("FAIL random[%0d]: s1=%0d s2=%0d se=%0b go=%0b w=%0d expected %0d/%0d/%0b/%0b/%0d",
                         i, score_p1, score_p2, serve_en, game_over, winner,
                         m_s1, m_s2, m_phase == 2, m_phase == 3, m_win);
            end
        end
    endtask

    initial begin
        model_step(0, 0, 0, 0, 1);
        test_reset();
        test_start();
        test_single_point();
        test_same_cycle();
        test_tie_and_extra();
        test_win();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
